// File: rtl/uart_tx_scheduler_if.sv
// Producer and uart-side handshake bundle for uart_tx_scheduler.
//   req / req_data   : per-producer request level and byte (byte i at [8i+7:8i])
//   ack              : one-hot capture pulse back to the producers
//   transmit/tx_byte : launch pulse and byte toward the uart core
//   is_transmitting  : uart line-busy flag
// master = scheduler side, slave = producers + uart side.
interface uart_tx_scheduler_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   ack;
   logic                 transmit;
   logic [7:0]           tx_byte;
   logic                 is_transmitting;

   modport master (
      input  req, req_data, is_transmitting,
      output ack, transmit, tx_byte
   );

   modport slave (
      output req, req_data, is_transmitting,
      input  ack, transmit, tx_byte
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart transmitter between NUM_REQ producers.
// One byte is taken per grant and launched with a single-cycle transmit pulse;
// the uart busy flag is then tracked, an optional gap is inserted, and a
// sticky error is raised if the uart never acknowledges a launch.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (master)    : req/req_data/ack producer handshake, transmit/tx_byte/
//                     is_transmitting uart connection
//   busy            : combinational, high whenever the FSM is not IDLE
//   last_grant      : index of the most recent grant
//   start_err       : sticky launch-timeout flag
//   err_clear       : clears start_err (a simultaneous set wins)
module uart_tx_scheduler #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned START_TIMEOUT = 16,
   parameter int unsigned GAP_CYCLES    = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   uart_tx_scheduler_if.master        bus,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic                       start_err,
   input  logic                       err_clear
);

   localparam int unsigned IDX_W    = $clog2(NUM_REQ);
   localparam int unsigned CNT_MAX  = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX);
   localparam int unsigned TO_LAST  = START_TIMEOUT - 1;
   // The cycle that observes is_transmitting low already counts as the first
   // idle gap cycle, so the GAP state itself lasts GAP_CYCLES-1 cycles.
   localparam int unsigned GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      WAIT_DONE  = 2'd2,
      GAP        = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [IDX_W-1:0]   last_grant_nxt;
   logic [NUM_REQ-1:0] ack_nxt;
   logic               transmit_nxt;
   logic [7:0]         tx_byte_nxt;
   logic               start_err_nxt;

   logic [7:0]         req_byte [NUM_REQ];
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;

   // Requester index 'off' positions after 'base', wrapping modulo NUM_REQ.
   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
      return IDX_W'((32'(base) + off) % NUM_REQ);
   endfunction

   // Unpack the flat producer byte bus.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         req_byte[i] = bus.req_data[8*i +: 8];
      end
   end

   // Round-robin winner: first set request after the last grant.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_grant;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         if (!win_found && bus.req[rr_index(last_grant, k)]) begin
            win_found = 1'b1;
            win_idx   = rr_index(last_grant, k);
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         last_grant   <= IDX_W'(NUM_REQ - 1);
         bus.ack      <= '0;
         bus.transmit <= 1'b0;
         bus.tx_byte  <= 8'h00;
         start_err    <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         last_grant   <= last_grant_nxt;
         bus.ack      <= ack_nxt;
         bus.transmit <= transmit_nxt;
         bus.tx_byte  <= tx_byte_nxt;
         start_err    <= start_err_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      last_grant_nxt = last_grant;
      ack_nxt        = '0;
      transmit_nxt   = 1'b0;
      tx_byte_nxt    = bus.tx_byte;
      start_err_nxt  = start_err & ~err_clear;

      case (state)
         IDLE: begin
            if (win_found && !bus.is_transmitting) begin
               tx_byte_nxt      = req_byte[win_idx];
               ack_nxt[win_idx] = 1'b1;
               transmit_nxt     = 1'b1;
               last_grant_nxt   = win_idx;
               cnt_nxt          = '0;
               state_nxt        = WAIT_START;
            end
         end
         WAIT_START: begin
            if (bus.is_transmitting) begin
               cnt_nxt   = '0;
               state_nxt = WAIT_DONE;
            end else if (cnt == CNT_W'(TO_LAST)) begin
               // Launch never acknowledged: byte is dropped, not retried.
               start_err_nxt = 1'b1;
               cnt_nxt       = '0;
               state_nxt     = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!bus.is_transmitting) begin
               cnt_nxt   = '0;
               state_nxt = (GAP_CYCLES > 1) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (cnt == CNT_W'(GAP_LAST)) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a default instance (GAP_CYCLES=0)
// with a controllable uart model, and a GAP_CYCLES=3 instance for gap timing.
module tb_uart_tx_scheduler;

   localparam int unsigned NR = 4;

   typedef struct packed {
      logic [1:0] idx;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_scheduler_if #(.NUM_REQ(NR)) u ();
   uart_tx_scheduler_if #(.NUM_REQ(NR)) g ();

   logic       busy, serr, eclr;
   logic [1:0] lg;
   logic       busy_g, serr_g, eclr_g;
   logic [1:0] lg_g;

   uart_tx_scheduler #(.NUM_REQ(NR), .START_TIMEOUT(16), .GAP_CYCLES(0)) dut (
      .clk(clk), .rst(rst), .bus(u), .busy(busy),
      .last_grant(lg), .start_err(serr), .err_clear(eclr)
   );

   uart_tx_scheduler #(.NUM_REQ(NR), .START_TIMEOUT(16), .GAP_CYCLES(3)) dut_g (
      .clk(clk), .rst(rst), .bus(g), .busy(busy_g),
      .last_grant(lg_g), .start_err(serr_g), .err_clear(eclr_g)
   );

   // uart models: busy for 10 cycles after each launch pulse
   int   m_cnt;
   int   gm_cnt;
   logic model_en;
   logic force_busy;

   always @(posedge clk) begin
      if (u.transmit && model_en) m_cnt <= 10;
      else if (m_cnt != 0)        m_cnt <= m_cnt - 1;
      if (g.transmit)             gm_cnt <= 10;
      else if (gm_cnt != 0)       gm_cnt <= gm_cnt - 1;
   end

   assign u.is_transmitting = force_busy | (m_cnt != 0);
   assign g.is_transmitting = (gm_cnt != 0);

   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk;
   int n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Scoreboard monitor on the default instance's launch pulses.
   exp_t exp_q[$];
   exp_t mon_e;
   logic tx_prev;
   logic chk_spacing;
   logic have_prev;
   int   last_tx_cyc;

   always @(negedge clk) begin
      if (!rst) begin
         if (tx_prev) check("pulse_end", 32'({u.ack, u.transmit}), 32'(0));
         if (u.transmit) begin
            if (exp_q.size() == 0) begin
               check("tx_unexpected", 32'(exp_q.size()), 32'(1));
            end else begin
               mon_e = exp_q.pop_front();
               check("tx_ack", 32'(u.ack), 32'(1) << mon_e.idx);
               check("tx_byte", 32'(u.tx_byte), 32'(mon_e.data));
               check("tx_last_grant", 32'(lg), 32'(mon_e.idx));
            end
            if (chk_spacing && have_prev)
               check("tx_spacing", 32'((cyc - last_tx_cyc) >= 11), 32'(1));
            have_prev   = 1'b1;
            last_tx_cyc = cyc;
         end
         tx_prev = u.transmit;
      end else begin
         tx_prev = 1'b0;
      end
   end

   task automatic push(input int idx, input logic [7:0] data);
      exp_t e;
      e.idx  = 2'(idx);
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(output logic [NR-1:0] a, output int n);
      a = '0;
      n = 0;
      while (a == '0 && n < 100) begin
         @(negedge clk);
         n++;
         a = u.ack;
      end
      if (a == '0) check("ack_within_budget", 32'(a != '0), 32'(1));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || u.is_transmitting) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy || u.is_transmitting) check("idle_within_budget", 32'(busy), 32'(0));
      repeat (2) @(negedge clk);
   endtask

   logic [NR-1:0] a;
   int            n;
   int            k;
   int            m_fall;
   logic          busy_all;

   initial begin
      rst = 1'b1; eclr = 1'b0; eclr_g = 1'b0;
      u.req = '0; u.req_data = '0; g.req = '0; g.req_data = '0;
      model_en = 1'b1; force_busy = 1'b0; m_cnt = 0; gm_cnt = 0; cyc = 0;
      n_chk = 0; n_pass = 0; tx_prev = 1'b0; chk_spacing = 1'b0;
      have_prev = 1'b0; last_tx_cyc = 0;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(u.ack), 32'(0));
      check("rst_transmit", 32'(u.transmit), 32'(0));
      check("rst_tx_byte", 32'(u.tx_byte), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_last_grant", 32'(lg), 32'(3));
      check("rst_start_err", 32'(serr), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      // contention: all four hold req, six grants in rotation
      chk_spacing = 1'b1;
      u.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int i = 0; i < 6; i++) push(i % 4, 8'hA0 + 8'(i % 4));
      u.req = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         wait_ack(a, n);
         check("cont_order", 32'(a), 32'(1) << (i % 4));
      end
      u.req = '0;
      wait_idle();
      chk_spacing = 1'b0;

      // single request
      u.req_data = 32'h0000_0038;
      push(0, 8'h38);
      u.req = 4'b0001;
      wait_ack(a, n);
      check("single_latency", 32'(n), 32'(1));
      u.req = '0;
      busy_all = 1'b1;
      k = 0;
      while (!u.is_transmitting && k < 20) begin @(negedge clk); busy_all &= busy; k++; end
      while (u.is_transmitting && k < 40) begin busy_all &= busy; @(negedge clk); k++; end
      check("single_busy_held", 32'(busy_all & busy), 32'(1));
      @(negedge clk);
      check("single_busy_drop", 32'(busy), 32'(0));
      wait_idle();

      // external busy holds off the grant
      force_busy = 1'b1;
      u.req_data = 32'h0000_7700;
      push(1, 8'h77);
      u.req = 4'b0010;
      busy_all = 1'b0;
      repeat (5) begin @(negedge clk); busy_all |= (u.ack != '0) | busy; end
      check("ext_busy_hold", 32'(busy_all), 32'(0));
      force_busy = 1'b0;
      @(negedge clk);
      check("ext_busy_ack", 32'(u.ack), 32'(4'b0010));
      u.req = '0;
      wait_idle();

      // launch timeout
      model_en = 1'b0;
      u.req_data = 32'h0000_0055;
      push(0, 8'h55);
      u.req = 4'b0001;
      wait_ack(a, n);
      u.req = '0;
      k = 0;
      while (!serr && k < 40) begin @(negedge clk); k++; end
      check("to_delay", 32'(k), 32'(16));
      check("to_idle", 32'(busy), 32'(0));
      eclr = 1'b1;
      @(negedge clk);
      eclr = 1'b0;
      check("to_clear", 32'(serr), 32'(0));
      u.req_data = 32'h0000_0056;
      push(0, 8'h56);
      u.req = 4'b0001;
      wait_ack(a, n);
      u.req = '0;
      repeat (15) @(negedge clk);
      eclr = 1'b1;
      @(negedge clk);
      check("to_set_wins", 32'(serr), 32'(1));
      @(negedge clk);
      eclr = 1'b0;
      check("to_lone_clear", 32'(serr), 32'(0));
      model_en = 1'b1;
      wait_idle();

      // async reset during WAIT_DONE
      u.req_data = 32'h0044_0000;
      push(2, 8'h44);
      u.req = 4'b0100;
      wait_ack(a, n);
      u.req = '0;
      repeat (4) @(negedge clk);
      check("rst_mid_busy", 32'(busy), 32'(1));
      #2 rst = 1'b1;
      #1;
      check("arst_transmit", 32'(u.transmit), 32'(0));
      check("arst_ack", 32'(u.ack), 32'(0));
      check("arst_busy", 32'(busy), 32'(0));
      check("arst_last_grant", 32'(lg), 32'(3));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_idle();
      u.req_data = {8'hD3, 8'h00, 8'h00, 8'hD0};
      push(0, 8'hD0);
      push(3, 8'hD3);
      u.req = 4'b1001;
      wait_ack(a, n);
      check("arst_first", 32'(a), 32'(4'b0001));
      u.req[0] = 1'b0;
      wait_ack(a, n);
      check("arst_second", 32'(a), 32'(4'b1000));
      u.req = '0;
      wait_idle();

      // GAP_CYCLES=3 instance: two requesters
      g.req_data = 32'h0000_2211;
      g.req = 4'b0011;
      k = 0;
      while (!g.transmit && k < 50) begin @(negedge clk); k++; end
      check("gap_first_ack", 32'(g.ack), 32'(4'b0001));
      check("gap_first_byte", 32'(g.tx_byte), 32'(8'h11));
      g.req[0] = 1'b0;
      k = 0;
      while (!g.is_transmitting && k < 20) begin @(negedge clk); k++; end
      while (g.is_transmitting && k < 40) begin @(negedge clk); k++; end
      m_fall = cyc;
      k = 0;
      while (!g.transmit && k < 20) begin @(negedge clk); k++; end
      check("gap_spacing", 32'(cyc - m_fall), 32'(4));
      check("gap_second_ack", 32'(g.ack), 32'(4'b0010));
      check("gap_second_byte", 32'(g.tx_byte), 32'(8'h22));
      g.req = '0;
      repeat (20) @(negedge clk);

      check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
